// File: rtl/sl_pkg.sv
// sl_pkg: shared definitions for the SL (serial-line) transceiver blocks.
//   - config register field indices and the power-on config value
//   - status register bit indices
//   - legal data-bit-count range
//   - transmitter FSM state encoding
//   - build_word(): masks a data word to BQ bits and places the parity bit at
//     position BQ, producing the complete LSB-first bit sequence to shift out.
package sl_pkg;

    // Config register fields
    localparam int CFG_PIE = 0;   // invert parity bit
    localparam int CFG_BQL = 1;   // data bit count, low index
    localparam int CFG_BQH = 6;   // data bit count, high index

    localparam int BQ_W = CFG_BQH - CFG_BQL + 1;

    // Status register bits
    localparam int ST_TXB = 0;    // transmitter busy
    localparam int ST_TXD = 1;    // word done (sticky)
    localparam int ST_CRJ = 2;    // config write rejected (sticky)
    localparam int ST_WRJ = 3;    // start request rejected (sticky)

    localparam logic [BQ_W-1:0] BQ_MIN = 6'd8;
    localparam logic [BQ_W-1:0] BQ_MAX = 6'd32;
    localparam logic [BQ_W-1:0] BQ_RESET = 6'd8;

    // Phase counter width (holds PULSE_LEN-1 / GAP_LEN-1)
    localparam int PHASE_W = 6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BIT_ACT  = 3'd1,
        S_BIT_GAP  = 3'd2,
        S_STOP_ACT = 3'd3,
        S_STOP_GAP = 3'd4
    } sl_state_t;

    // Data bits [bq-1:0] followed by the parity bit at index bq. Parity makes
    // the count of ones over data+parity odd; pie flips it.
    function automatic logic [32:0] build_word(
        input logic [31:0]     data,
        input logic [BQ_W-1:0] bq,
        input logic            pie
    );
        logic [32:0] mask;
        logic [32:0] masked;
        logic        par;
        mask   = (33'd1 << bq) - 33'd1;
        masked = {1'b0, data} & mask;
        par    = ~(^masked) ^ pie;
        return masked | ({32'd0, par} << bq);
    endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// sl_phase_timer: loadable down-counter timing one line phase.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   terminal   : high while the count sits at zero, i.e. during the last
//                cycle of the phase; the owner switches phase on the next edge
module sl_phase_timer
    import sl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               terminal
);

    logic [PHASE_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign terminal = (count_reg == '0);

endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: SL bus word transmitter.
// Serialises one word LSB-first as BQ data bits, one odd-parity bit and one
// stop symbol. Every symbol is an active phase of PULSE_LEN cycles followed by
// a both-high gap of GAP_LEN cycles.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_data, wr_enable  : word to send and start strobe (honoured in IDLE only)
//   wr_config_w,
//   config_wr_enable    : config write (PIE bit 0, BQ bits 6:1)
//   done_picked         : clears the TXD flag
//   serial_line_zeroes,
//   serial_line_ones    : registered SL wires (idle = both high)
//   r_config_w          : current config
//   status_w            : TXB/TXD/CRJ/WRJ
//   data_status_changed : one-cycle pulse on word start and completion
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int CONFIG_WIDTH = 16,
    parameter int STATUS_WIDTH = 16,
    parameter int PULSE_LEN    = 16,
    parameter int GAP_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             wr_data,
    input  logic                    wr_enable,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    config_wr_enable,
    input  logic                    done_picked,
    output logic                    serial_line_zeroes,
    output logic                    serial_line_ones,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    output logic [STATUS_WIDTH-1:0] status_w,
    output logic                    data_status_changed
);

    localparam logic [PHASE_W-1:0] PULSE_LOAD = PHASE_W'(PULSE_LEN - 1);
    localparam logic [PHASE_W-1:0] GAP_LOAD   = PHASE_W'(GAP_LEN - 1);

    sl_state_t       state_reg;
    logic [32:0]     shift_reg;
    logic [BQ_W-1:0] bq_lat_reg;
    logic [BQ_W-1:0] bit_cnt_reg;
    logic            zeroes_reg;
    logic            ones_reg;
    logic            dsc_reg;
    logic            txb_reg;
    logic            txd_reg;
    logic            crj_reg;
    logic            wrj_reg;
    logic [BQ_W-1:0] cfg_bq_reg;
    logic            cfg_pie_reg;

    logic            phase_done;
    logic            timer_load;
    logic [PHASE_W-1:0] timer_val;
    logic            start;
    logic            complete;
    logic [BQ_W-1:0] cfg_bq_w;
    logic            cfg_ok;
    logic            cfg_accept;
    logic            cfg_reject;
    logic [32:0]     first_word;
    logic            unused_cfg_bits;

    assign unused_cfg_bits = ^wr_config_w[CONFIG_WIDTH-1:CFG_BQH+1];

    assign start    = (state_reg == S_IDLE) && wr_enable;
    assign complete = (state_reg == S_STOP_GAP) && phase_done;

    // Timer reload on every phase change; active phases follow IDLE and
    // BIT_GAP, gaps follow the two active states.
    assign timer_load = start || ((state_reg != S_IDLE) && phase_done);
    assign timer_val  = ((state_reg == S_IDLE) || (state_reg == S_BIT_GAP))
                        ? PULSE_LOAD : GAP_LOAD;

    sl_phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .terminal (phase_done)
    );

    // Config write qualification
    assign cfg_bq_w   = wr_config_w[CFG_BQH:CFG_BQL];
    assign cfg_ok     = !cfg_bq_w[0] && (cfg_bq_w >= BQ_MIN) && (cfg_bq_w <= BQ_MAX);
    assign cfg_accept = config_wr_enable && (state_reg == S_IDLE) && cfg_ok;
    assign cfg_reject = config_wr_enable && !cfg_accept;

    assign first_word = build_word(wr_data, cfg_bq_reg, cfg_pie_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_bq_reg  <= BQ_RESET;
            cfg_pie_reg <= 1'b0;
        end else if (cfg_accept) begin
            cfg_bq_reg  <= cfg_bq_w;
            cfg_pie_reg <= wr_config_w[CFG_PIE];
        end
    end

    // Main FSM; line outputs are registered alongside the state so the wires
    // change on the same edge as the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bq_lat_reg  <= BQ_RESET;
            bit_cnt_reg <= '0;
            zeroes_reg  <= 1'b1;
            ones_reg    <= 1'b1;
            txb_reg     <= 1'b0;
            dsc_reg     <= 1'b0;
        end else begin
            dsc_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (wr_enable) begin
                        state_reg   <= S_BIT_ACT;
                        shift_reg   <= first_word;
                        bq_lat_reg  <= cfg_bq_reg;
                        bit_cnt_reg <= '0;
                        zeroes_reg  <= first_word[0];
                        ones_reg    <= ~first_word[0];
                        txb_reg     <= 1'b1;
                        dsc_reg     <= 1'b1;
                    end
                end
                S_BIT_ACT: begin
                    if (phase_done) begin
                        state_reg  <= S_BIT_GAP;
                        zeroes_reg <= 1'b1;
                        ones_reg   <= 1'b1;
                    end
                end
                S_BIT_GAP: begin
                    if (phase_done) begin
                        // bit index bq is the parity bit, the last one sent
                        if (bit_cnt_reg == bq_lat_reg) begin
                            state_reg  <= S_STOP_ACT;
                            zeroes_reg <= 1'b0;
                            ones_reg   <= 1'b0;
                        end else begin
                            state_reg   <= S_BIT_ACT;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            zeroes_reg  <= shift_reg[1];
                            ones_reg    <= ~shift_reg[1];
                        end
                    end
                end
                S_STOP_ACT: begin
                    if (phase_done) begin
                        state_reg  <= S_STOP_GAP;
                        zeroes_reg <= 1'b1;
                        ones_reg   <= 1'b1;
                    end
                end
                S_STOP_GAP: begin
                    if (phase_done) begin
                        state_reg <= S_IDLE;
                        txb_reg   <= 1'b0;
                        dsc_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    zeroes_reg <= 1'b1;
                    ones_reg   <= 1'b1;
                    txb_reg    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_reg <= 1'b0;
            crj_reg <= 1'b0;
            wrj_reg <= 1'b0;
        end else begin
            // completion beats a simultaneous done_picked
            if (complete) begin
                txd_reg <= 1'b1;
            end else if (done_picked || start) begin
                txd_reg <= 1'b0;
            end

            if (cfg_reject) begin
                crj_reg <= 1'b1;
            end else if (cfg_accept) begin
                crj_reg <= 1'b0;
            end

            if (wr_enable && (state_reg != S_IDLE)) begin
                wrj_reg <= 1'b1;
            end else if (start) begin
                wrj_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        r_config_w                  = '0;
        r_config_w[CFG_PIE]         = cfg_pie_reg;
        r_config_w[CFG_BQH:CFG_BQL] = cfg_bq_reg;
    end

    always_comb begin
        status_w         = '0;
        status_w[ST_TXB] = txb_reg;
        status_w[ST_TXD] = txd_reg;
        status_w[ST_CRJ] = crj_reg;
        status_w[ST_WRJ] = wrj_reg;
    end

    assign serial_line_zeroes  = zeroes_reg;
    assign serial_line_ones    = ones_reg;
    assign data_status_changed = dsc_reg;

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: directed bench for sl_transmitter (PULSE_LEN=GAP_LEN=16).
// Each word is checked cycle by cycle against hand-computed bit sequences.
module tb_sl_transmitter;

    localparam int PULSE   = 16;
    localparam int BIT_CYC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic [15:0] wr_config_w;
    logic        config_wr_enable;
    logic        done_picked;
    logic        serial_line_zeroes;
    logic        serial_line_ones;
    logic [15:0] r_config_w;
    logic [15:0] status_w;
    logic        data_status_changed;

    int checks = 0;
    int errors = 0;

    sl_transmitter #(
        .CONFIG_WIDTH (16),
        .STATUS_WIDTH (16),
        .PULSE_LEN    (16),
        .GAP_LEN      (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wr_data             (wr_data),
        .wr_enable           (wr_enable),
        .wr_config_w         (wr_config_w),
        .config_wr_enable    (config_wr_enable),
        .done_picked         (done_picked),
        .serial_line_zeroes  (serial_line_zeroes),
        .serial_line_ones    (serial_line_ones),
        .r_config_w          (r_config_w),
        .status_w            (status_w),
        .data_status_changed (data_status_changed)
    );

    always #5 clk = ~clk;

    task automatic write_config(input logic [15:0] val);
        wr_config_w      = val;
        config_wr_enable = 1'b1;
        @(posedge clk); #1;
        config_wr_enable = 1'b0;
        $display("cfg write %h -> config %h status %h", val, r_config_w, status_w);
    endtask

    // Sends one word and checks every cycle of it. exp_bits holds the data
    // bits plus parity (nbits = BQ+1). inject >= 0 raises wr_enable and a
    // config write for one cycle at that cycle offset. pick_at_end raises
    // done_picked on the completion edge.
    task automatic run_word(input logic [31:0] data, input int nbits,
                            input logic [32:0] exp_bits, input int inject,
                            input bit pick_at_end, input string name);
        int   bad;
        int   dsc_seen;
        int   total;
        int   first_c;
        logic exp_z;
        logic exp_o;
        logic got_z;
        logic got_o;
        bad      = 0;
        dsc_seen = 0;
        first_c  = -1;
        got_z    = 1'b0;
        got_o    = 1'b0;
        total    = (nbits + 1) * BIT_CYC;
        wr_data   = data;
        wr_enable = 1'b1;
        @(posedge clk); #1;
        wr_enable = 1'b0;
        checks++;
        if (status_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s start_txb got %b want 1", name, status_w[0]);
        end
        for (int c = 0; c < total; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == inject) begin
                wr_enable        = 1'b1;
                wr_data          = ~data;
                wr_config_w      = 16'h0020;
                config_wr_enable = 1'b1;
            end else if (c == inject + 1) begin
                wr_enable        = 1'b0;
                config_wr_enable = 1'b0;
            end
            if (c == total - 1) done_picked = pick_at_end;
            if (data_status_changed === 1'b1) dsc_seen++;
            if ((c % BIT_CYC) >= PULSE) begin
                exp_z = 1'b1; exp_o = 1'b1;
            end else if ((c / BIT_CYC) < nbits) begin
                exp_z = exp_bits[c / BIT_CYC];
                exp_o = ~exp_bits[c / BIT_CYC];
            end else begin
                exp_z = 1'b0; exp_o = 1'b0;
            end
            if (serial_line_zeroes !== exp_z || serial_line_ones !== exp_o ||
                status_w[0] !== 1'b1 || status_w[1] !== 1'b0) begin
                if (bad == 0) begin
                    first_c = c;
                    got_z   = serial_line_zeroes;
                    got_o   = serial_line_ones;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s lines %0d bad cycles, first at %0d got z/o %b%b want %b%b",
                     name, bad, first_c, got_z, got_o,
                     ((first_c % BIT_CYC) >= PULSE) ? 1'b1 :
                     ((first_c / BIT_CYC) < nbits) ? exp_bits[first_c / BIT_CYC] : 1'b0,
                     ((first_c % BIT_CYC) >= PULSE) ? 1'b1 :
                     ((first_c / BIT_CYC) < nbits) ? ~exp_bits[first_c / BIT_CYC] : 1'b0);
        end
        // completion edge
        @(posedge clk); #1;
        done_picked = 1'b0;
        if (data_status_changed === 1'b1) dsc_seen++;
        checks++;
        if (status_w[1] !== 1'b1 || status_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s end_status got txd %b txb %b want txd 1 txb 0",
                     name, status_w[1], status_w[0]);
        end
        checks++;
        if (dsc_seen != 2) begin
            errors++;
            $display("FAIL %s dsc_pulses got %0d want 2", name, dsc_seen);
        end
        checks++;
        if (serial_line_zeroes !== 1'b1 || serial_line_ones !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_lines got %b%b want 11", name,
                     serial_line_zeroes, serial_line_ones);
        end
        $display("word %s data %h bits %0d done after %0d cycles status %h",
                 name, data, nbits, total, status_w);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_data = '0; wr_enable = 1'b0; wr_config_w = '0;
        config_wr_enable = 1'b0; done_picked = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (serial_line_zeroes !== 1'b1 || serial_line_ones !== 1'b1) begin
            errors++;
            $display("FAIL reset_lines got %b%b want 11", serial_line_zeroes, serial_line_ones);
        end
        checks++;
        if (status_w !== 16'h0000) begin
            errors++;
            $display("FAIL reset_status got %h want 0000", status_w);
        end
        checks++;
        if (r_config_w !== 16'h0010) begin
            errors++;
            $display("FAIL reset_config got %h want 0010", r_config_w);
        end
        checks++;
        if (data_status_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_dsc got %b want 0", data_status_changed);
        end
        $display("reset: status %h config %h", status_w, r_config_w);
    endtask

    task automatic test_default_word();
        // 0xA5 has four ones -> parity 1
        run_word(32'h0000_00A5, 9, 33'h1A5, -1, 1'b0, "a5");
        done_picked = 1'b1;
        @(posedge clk); #1;
        done_picked = 1'b0;
        checks++;
        if (status_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL done_picked_clear got txd %b want 0", status_w[1]);
        end
        $display("done_picked: status %h", status_w);
    endtask

    task automatic test_config_reject();
        write_config(16'h000E);   // BQ=7
        checks++;
        if (status_w[2] !== 1'b1 || r_config_w !== 16'h0010) begin
            errors++;
            $display("FAIL cfg_bq7 got crj %b config %h want crj 1 config 0010",
                     status_w[2], r_config_w);
        end
        write_config(16'h0044);   // BQ=34
        checks++;
        if (status_w[2] !== 1'b1 || r_config_w !== 16'h0010) begin
            errors++;
            $display("FAIL cfg_bq34 got crj %b config %h want crj 1 config 0010",
                     status_w[2], r_config_w);
        end
        write_config(16'h0020);   // BQ=16
        checks++;
        if (status_w[2] !== 1'b0 || r_config_w !== 16'h0020) begin
            errors++;
            $display("FAIL cfg_bq16 got crj %b config %h want crj 0 config 0020",
                     status_w[2], r_config_w);
        end
    endtask

    task automatic test_bq32();
        write_config(16'hFF40);   // BQ=32, upper bits read back as 0
        checks++;
        if (r_config_w !== 16'h0040) begin
            errors++;
            $display("FAIL cfg_bq32 got config %h want 0040", r_config_w);
        end
        // 32 ones -> parity 1; 34*32 cycles total
        run_word(32'hFFFF_FFFF, 33, 33'h1_FFFF_FFFF, -1, 1'b0, "ffffffff");
    endtask

    task automatic test_back_to_back();
        write_config(16'h0010);
        // 0x3C has four ones -> parity 1; start request + config write at cycle 50
        run_word(32'h0000_003C, 9, 33'h13C, 50, 1'b0, "wrj_word");
        checks++;
        if (status_w[3] !== 1'b1 || status_w[2] !== 1'b1 || r_config_w !== 16'h0010) begin
            errors++;
            $display("FAIL wrj_flags got wrj %b crj %b config %h want 1 1 0010",
                     status_w[3], status_w[2], r_config_w);
        end
        // started the cycle after completion; bits above BQ ignored: 0x01 -> parity 0
        run_word(32'hABCD_0001, 9, 33'h001, -1, 1'b1, "b2b");
        checks++;
        if (status_w[3] !== 1'b0) begin
            errors++;
            $display("FAIL wrj_clear got wrj %b want 0", status_w[3]);
        end
    endtask

    task automatic test_pie();
        write_config(16'h0011);
        checks++;
        if (status_w[2] !== 1'b0 || r_config_w !== 16'h0011) begin
            errors++;
            $display("FAIL cfg_pie got crj %b config %h want crj 0 config 0011",
                     status_w[2], r_config_w);
        end
        // 0x00: normal parity 1, inverted -> 0
        run_word(32'h0000_0000, 9, 33'h000, -1, 1'b0, "pie");
    endtask

    task automatic test_reset_midword();
        wr_data   = 32'h0000_005A;
        wr_enable = 1'b1;
        @(posedge clk); #1;
        wr_enable = 1'b0;
        repeat (3 * BIT_CYC + 4) @(posedge clk);
        #1;
        checks++;
        if (serial_line_zeroes !== 1'b1 || serial_line_ones !== 1'b0) begin
            errors++;
            $display("FAIL bit3_before_rst got z/o %b%b want 10",
                     serial_line_zeroes, serial_line_ones);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (serial_line_zeroes !== 1'b1 || serial_line_ones !== 1'b1) begin
            errors++;
            $display("FAIL midword_rst_lines got %b%b want 11",
                     serial_line_zeroes, serial_line_ones);
        end
        checks++;
        if (status_w !== 16'h0000 || r_config_w !== 16'h0010 || data_status_changed !== 1'b0) begin
            errors++;
            $display("FAIL midword_rst_regs got status %h config %h dsc %b want 0000 0010 0",
                     status_w, r_config_w, data_status_changed);
        end
        $display("midword reset: status %h config %h", status_w, r_config_w);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // default config again: 0x5A four ones -> parity 1
        run_word(32'h0000_005A, 9, 33'h15A, -1, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_default_word();
        test_config_reject();
        test_bq32();
        test_back_to_back();
        test_pie();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
